// File: rtl/sdr_tune_ctrl.sv
// UART command-frame parser that validates framed config writes and atomically
// updates the NCO phase increment and CIC decimation ratio, answering ACK/NAK.
module sdr_tune_ctrl #(
    parameter logic [63:0] RESET_PHASE_INC = 64'h1B1B4294E949F45,
    parameter logic [15:0] RESET_DECIM     = 16'd4096,
    parameter int unsigned TIMEOUT_CYCLES  = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    output logic [63:0] phase_inc,
    output logic [15:0] decim_ratio,
    output logic        cfg_update,
    output logic        frame_err
);

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] ACK_BYTE     = 8'h06;
    localparam logic [7:0] NAK_BYTE     = 8'h15;
    localparam logic [7:0] CMD_PHASE    = 8'h01;
    localparam logic [7:0] CMD_DECIM    = 8'h02;
    localparam logic [7:0] CMD_DEFAULTS = 8'h03;

    typedef enum logic [2:0] {
        IDLE, CMD, PAYLOAD, CHECK, APPLY, RESP, WAIT_TX
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  xor_q, xor_d;
    logic [63:0] stage_q, stage_d;
    logic [31:0] gap_q, gap_d;
    logic        pending_q, pending_d;
    logic        nak_q, nak_d;
    logic [63:0] phase_q, phase_d;
    logic [15:0] decim_q, decim_d;
    logic        tx_dv_q, tx_dv_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        cfg_update_q, cfg_update_d;
    logic        frame_err_q, frame_err_d;
    logic        in_frame;
    logic        timeout;

    assign in_frame = (state_q == CMD) || (state_q == PAYLOAD) || (state_q == CHECK);
    // A pending CHECK decision resolves next cycle, so it is exempt from timeout.
    assign timeout  = in_frame && !pending_q && !rx_dv
                   && (gap_q == TIMEOUT_CYCLES - 32'd1);

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        count_d      = count_q;
        xor_d        = xor_q;
        stage_d      = stage_q;
        pending_d    = pending_q;
        nak_d        = nak_q;
        phase_d      = phase_q;
        decim_d      = decim_q;
        tx_byte_d    = tx_byte_q;
        tx_dv_d      = 1'b0;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;
        gap_d        = '0;

        if (in_frame && !rx_dv) begin
            gap_d = gap_q + 32'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (rx_dv && rx_byte == SYNC_BYTE) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (rx_dv) begin
                    cmd_d     = rx_byte;
                    xor_d     = rx_byte;
                    pending_d = 1'b0;
                    nak_d     = 1'b0;
                    case (rx_byte)
                        CMD_PHASE: begin
                            count_d = 4'd8;
                            state_d = PAYLOAD;
                        end
                        CMD_DECIM: begin
                            count_d = 4'd2;
                            state_d = PAYLOAD;
                        end
                        CMD_DEFAULTS: begin
                            count_d = 4'd0;
                            state_d = CHECK;
                        end
                        default: begin
                            // Reuse the CHECK decision cycle to issue the NAK.
                            count_d   = 4'd0;
                            pending_d = 1'b1;
                            nak_d     = 1'b1;
                            state_d   = CHECK;
                        end
                    endcase
                end
            end
            PAYLOAD: begin
                if (rx_dv) begin
                    stage_d = {stage_q[55:0], rx_byte};
                    xor_d   = xor_q ^ rx_byte;
                    count_d = count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    if (nak_q || (cmd_q == CMD_DECIM && stage_q[15:0] < 16'd2)) begin
                        frame_err_d = 1'b1;
                        tx_byte_d   = NAK_BYTE;
                        state_d     = RESP;
                    end else begin
                        state_d = APPLY;
                    end
                end else if (rx_dv) begin
                    nak_d     = (rx_byte != xor_q);
                    pending_d = 1'b1;
                end
            end
            APPLY: begin
                case (cmd_q)
                    CMD_PHASE: phase_d = stage_q;
                    CMD_DECIM: decim_d = stage_q[15:0];
                    default: begin
                        phase_d = RESET_PHASE_INC;
                        decim_d = RESET_DECIM;
                    end
                endcase
                cfg_update_d = 1'b1;
                tx_byte_d    = ACK_BYTE;
                state_d      = RESP;
            end
            RESP: begin
                if (!tx_active) begin
                    tx_dv_d = 1'b1;
                    state_d = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            count_q      <= '0;
            xor_q        <= '0;
            stage_q      <= '0;
            gap_q        <= '0;
            pending_q    <= 1'b0;
            nak_q        <= 1'b0;
            phase_q      <= RESET_PHASE_INC;
            decim_q      <= RESET_DECIM;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            count_q      <= count_d;
            xor_q        <= xor_d;
            stage_q      <= stage_d;
            gap_q        <= gap_d;
            pending_q    <= pending_d;
            nak_q        <= nak_d;
            phase_q      <= phase_d;
            decim_q      <= decim_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign tx_dv       = tx_dv_q;
    assign tx_byte     = tx_byte_q;
    assign phase_inc   = phase_q;
    assign decim_ratio = decim_q;
    assign cfg_update  = cfg_update_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Self-checking bench for sdr_tune_ctrl: directed and randomized frames checked
// against a frame-level model of the expected ACK/NAK, timing and config values.
module tb_sdr_tune_ctrl;

    localparam logic [63:0] RST_PHASE = 64'h1B1B4294E949F45;
    localparam logic [15:0] RST_DECIM = 16'd4096;
    localparam int          TMO       = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [63:0] phase_inc;
    logic [15:0] decim_ratio;
    logic        cfg_update;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] model_phase = RST_PHASE;
    logic [15:0] model_decim = RST_DECIM;

    sdr_tune_ctrl #(
        .RESET_PHASE_INC(RST_PHASE),
        .RESET_DECIM    (RST_DECIM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .phase_inc  (phase_inc),
        .decim_ratio(decim_ratio),
        .cfg_update (cfg_update),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) begin
            if (i > 0) repeat ($urandom_range(0, 2)) step();
            rx_dv   = 1'b1;
            rx_byte = q[i];
            step();
            rx_dv   = 1'b0;
        end
    endtask

    // Records the edge (counted from the last byte's edge) of each output event.
    task automatic observe(input int win, input int rel,
                           output int cu_at, output int fe_at, output int tx_at,
                           output int n_tx, output logic [7:0] tx_b);
        cu_at = 0; fe_at = 0; tx_at = 0; n_tx = 0; tx_b = 8'h00;
        for (int c = 1; c <= win; c++) begin
            step();
            if (cfg_update && cu_at == 0) cu_at = c;
            if (frame_err && fe_at == 0) fe_at = c;
            if (tx_dv) begin
                n_tx++;
                if (tx_at == 0) begin
                    tx_at = c;
                    tx_b  = tx_byte;
                end
            end
            if (c == rel) tx_active = 1'b0;
        end
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic check_cfg(input string tag);
        check({tag, " phase_inc"}, phase_inc, model_phase);
        check({tag, " decim_ratio"}, {48'd0, decim_ratio}, {48'd0, model_decim});
    endtask

    // Builds a frame from the command rules, predicts ACK/NAK, and checks timing.
    task automatic do_cmd(input logic [7:0] cmd, input logic [63:0] val,
                          input bit corrupt, input int rel, input string tag);
        logic [7:0] q[$];
        logic [7:0] chk;
        logic [7:0] tx_b;
        int n, cu_at, fe_at, tx_at, n_tx;
        bit known, ack;
        known = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03);
        n = (cmd == 8'h01) ? 8 : (cmd == 8'h02) ? 2 : 0;
        q.push_back(8'hA5);
        q.push_back(cmd);
        chk = cmd;
        if (known) begin
            for (int i = n - 1; i >= 0; i--) begin
                q.push_back(val[i*8 +: 8]);
                chk ^= val[i*8 +: 8];
            end
            q.push_back(corrupt ? (chk ^ 8'($urandom_range(1, 255))) : chk);
        end
        ack = known && !corrupt && !(cmd == 8'h02 && val[15:0] < 16'd2);
        if (ack) begin
            if (cmd == 8'h01) model_phase = val;
            else if (cmd == 8'h02) model_decim = val[15:0];
            else begin
                model_phase = RST_PHASE;
                model_decim = RST_DECIM;
            end
        end
        if (rel > 0) tx_active = 1'b1;
        send_bytes(q);
        observe((rel + 4 > 8) ? rel + 4 : 8, rel, cu_at, fe_at, tx_at, n_tx, tx_b);
        check({tag, " cfg_update edge"}, cu_at, ack ? 2 : 0);
        check({tag, " frame_err edge"}, fe_at, ack ? 0 : 1);
        check({tag, " tx_dv edge"}, tx_at, ack ? ((rel > 0) ? rel + 1 : 3) : 2);
        check({tag, " tx_dv count"}, n_tx, 1);
        check({tag, " tx_byte"}, tx_b, ack ? 8'h06 : 8'h15);
        pulse_tx_done();
        check({tag, " held tx_byte"}, tx_byte, ack ? 8'h06 : 8'h15);
        check_cfg(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] tx_b;
        logic [7:0] rc;
        int cu_at, fe_at, tx_at, n_tx;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset phase_inc", phase_inc, RST_PHASE);
        check("reset decim_ratio", {48'd0, decim_ratio}, 64'd4096);
        check("reset tx_dv", tx_dv, 0);
        check("reset tx_byte", tx_byte, 0);
        check("reset cfg_update", cfg_update, 0);
        check("reset frame_err", frame_err, 0);

        do_cmd(8'h01, 64'h0123456789ABCDEF, 1'b0, 0, "phase");
        // Bad checksum: 0x13 instead of 0x12.
        q = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h13};
        send_bytes(q);
        observe(8, 0, cu_at, fe_at, tx_at, n_tx, tx_b);
        check("badchk frame_err edge", fe_at, 1);
        check("badchk cfg_update", cu_at, 0);
        check("badchk tx_dv edge", tx_at, 2);
        check("badchk tx_byte", tx_b, 8'h15);
        pulse_tx_done();
        check_cfg("badchk");

        do_cmd(8'h02, 64'h0001, 1'b0, 0, "decim one");
        do_cmd(8'h02, 64'h0000, 1'b0, 0, "decim zero");
        do_cmd(8'h7E, 64'h0, 1'b0, 0, "unknown cmd");

        q = '{8'h00, 8'hFF};
        send_bytes(q);
        do_cmd(8'h02, 64'h1234, 1'b0, 0, "garbage then decim");
        do_cmd(8'h02, 64'h0002, 1'b0, 0, "decim min");
        do_cmd(8'h01, 64'hA5A5_0000_A5FF_A501, 1'b0, 5, "busy phase");

        // Timeout: three payload bytes then silence.
        q = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33};
        send_bytes(q);
        observe(TMO + 10, 0, cu_at, fe_at, tx_at, n_tx, tx_b);
        check("timeout frame_err edge", fe_at, TMO);
        check("timeout tx_dv count", n_tx, 0);
        check("timeout cfg_update", cu_at, 0);
        check_cfg("timeout");
        do_cmd(8'h01, 64'hFEDC_BA98_7654_3210, 1'b0, 0, "after timeout");

        do_cmd(8'h03, 64'h0, 1'b0, 0, "defaults");

        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 3))
                0: rc = 8'h01;
                1: rc = 8'h02;
                2: rc = 8'h03;
                default: rc = 8'($urandom_range(4, 255));
            endcase
            do_cmd(rc,
                   ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 2))
                                               : {32'($urandom), 32'($urandom)},
                   ($urandom_range(0, 3) == 0), 0, "random");
        end

        do_cmd(8'h01, 64'h0F0F_1234_5678_9ABC, 1'b0, 0, "pre reset");
        // Reset mid-payload, colliding with an incoming byte.
        q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(q);
        rst     = 1'b1;
        rx_dv   = 1'b1;
        rx_byte = 8'h05;
        step();
        rst   = 1'b0;
        rx_dv = 1'b0;
        model_phase = RST_PHASE;
        model_decim = RST_DECIM;
        check_cfg("mid reset");
        check("mid reset tx_byte", tx_byte, 0);
        check("mid reset tx_dv", tx_dv, 0);
        do_cmd(8'h02, 64'h0100, 1'b0, 0, "after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
